// File: rtl/div_half_checker_if.sv
// div_half_checker_if: divided-clock input, enable and measurement results of the half-integer divider checker.
interface div_half_checker_if #(parameter int CNT_W = 16);
    logic             clk_div_in;
    logic             meas_en;
    logic [CNT_W-1:0] period_x2;
    logic             valid;
    logic             match;
    logic             lock;
    logic             err;
    modport master (output clk_div_in, meas_en, input period_x2, valid, match, lock, err);
    modport slave  (input clk_div_in, meas_en, output period_x2, valid, match, lock, err);
endinterface

// File: rtl/div_half_checker.sv
// div_half_checker: measures two periods of a divided clock in clk cycles and checks them against NUM_X2 +/- TOL,
// flagging each result, a lock after LOCK_CNT consecutive matches, and a timeout error.
module div_half_checker #(
    parameter int NUM_X2      = 9,
    parameter int TOL         = 1,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input logic clk,
    input logic rst_n,
    div_half_checker_if.slave bus
);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_CNT);
    typedef enum logic [1:0] {IDLE, SYNC, MEAS} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d, edge_p;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
    logic edge_idx_q, edge_idx_d, valid_q, valid_d, match_q, match_d;
    logic lock_q, lock_d, err_q, err_d, hit, at_max;
    logic [RW-1:0] run_q, run_d;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0] adiff;
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.clk_div_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        edge_p     = sync_q[SYNC_STAGES-1] & ~prev_q;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        at_max     = (cnt_inc == CNT_MAX);
        diff       = $signed({1'b0, cnt_q}) - $signed((CNT_W+1)'(NUM_X2));
        adiff      = $unsigned(diff[CNT_W] ? -diff : diff);
        hit        = (adiff <= (CNT_W+1)'(TOL));
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_idx_d = edge_idx_q;
        run_d      = run_q;
        period_d   = period_q;
        match_d    = match_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (!bus.meas_en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            edge_idx_d = 1'b0;
            run_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    cnt_d   = '0;
                end
                SYNC: begin
                    if (edge_p) begin
                        state_d    = MEAS;
                        cnt_d      = CNT_W'(1);
                        edge_idx_d = 1'b0;
                    end else if (at_max) begin
                        err_d = 1'b1;
                        run_d = '0;
                        cnt_d = '0;
                    end else cnt_d = cnt_inc;
                end
                default: begin
                    if (edge_p && !edge_idx_q) begin
                        edge_idx_d = 1'b1;
                        cnt_d      = cnt_inc;
                    end else if (edge_p) begin
                        // end edge doubles as the next start edge
                        period_d   = cnt_q;
                        match_d    = hit;
                        valid_d    = 1'b1;
                        cnt_d      = CNT_W'(1);
                        edge_idx_d = 1'b0;
                        run_d      = !hit ? '0 : (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
                    end else if (at_max) begin
                        err_d      = 1'b1;
                        run_d      = '0;
                        state_d    = SYNC;
                        cnt_d      = '0;
                        edge_idx_d = 1'b0;
                    end else cnt_d = cnt_inc;
                end
            endcase
        end
        lock_d = (run_d == RUN_MAX);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            edge_idx_q <= 1'b0;
            run_q      <= '0;
            period_q   <= '0;
            match_q    <= 1'b0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            edge_idx_q <= edge_idx_d;
            run_q      <= run_d;
            period_q   <= period_d;
            match_q    <= match_d;
            valid_q    <= valid_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
        end
    end
    assign bus.period_x2 = period_q;
    assign bus.valid     = valid_q;
    assign bus.match     = match_q;
    assign bus.lock      = lock_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_div_half_checker.sv
// tb_div_half_checker: directed checks of two checkers (TOL=1 and TOL=0, CNT_W=6) fed by a behavioural
// divided-clock source whose periods can be 4/5 alternating, constant 5, stretched, or stuck low.
module tb_div_half_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic div_in = 1'b0;
    logic en = 1'b0;
    int mode = 0;
    int pend = 0;
    int pend_from = 0;
    int pass_n = 0;
    int total_n = 0;
    div_half_checker_if #(.CNT_W(6)) bi ();
    div_half_checker_if #(.CNT_W(6)) bz ();
    assign bi.clk_div_in = div_in;
    assign bi.meas_en    = en;
    assign bz.clk_div_in = div_in;
    assign bz.meas_en    = en;
    div_half_checker #(.NUM_X2(9), .TOL(1), .CNT_W(6), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));
    div_half_checker #(.NUM_X2(9), .TOL(0), .CNT_W(6), .SYNC_STAGES(2), .LOCK_CNT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bz));
    always #5 clk = ~clk;
    // source: mode 45 alternates 4/5-cycle periods, mode 5 is constant 5, mode 0 holds low
    initial begin
        int ph, len, base;
        bit alt;
        ph = 0; len = 4; alt = 1'b0;
        forever begin
            @(negedge clk);
            if (ph >= len - 1) begin
                ph = 0;
                alt = ~alt;
                base = (mode == 5) ? 5 : (alt ? 5 : 4);
                len = base;
                if (pend != 0 && base == pend_from) begin
                    len = 6;
                    pend = 0;
                end
            end else ph++;
            div_in = (mode != 0) && (ph < 2);
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget && !ok) begin
            tick;
            n++;
            if (bi.valid) ok = 1'b1;
        end
    endtask
    task automatic test_reset;
        #2;
        total_n++; if (bi.period_x2 !== 6'd0 || bi.valid !== 1'b0 || bi.match !== 1'b0) $display("FAIL reset_data got p=%0d v=%b m=%b want 0 0 0", bi.period_x2, bi.valid, bi.match); else pass_n++;
        total_n++; if (bi.lock !== 1'b0 || bi.err !== 1'b0 || bz.lock !== 1'b0) $display("FAIL reset_flags got l=%b e=%b l0=%b want 0 0 0", bi.lock, bi.err, bz.lock); else pass_n++;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask
    task automatic test_ratio_45;
        int n; bit ok;
        mode = 45; en = 1'b1;
        wait_valid(80, n, ok);
        total_n++; if (!ok) $display("FAIL first_valid got timeout want valid"); else pass_n++;
        total_n++; if (bi.period_x2 !== 6'd9 || bi.match !== 1'b1 || bi.lock !== 1'b0) $display("FAIL first_meas got p=%0d m=%b l=%b want 9 1 0", bi.period_x2, bi.match, bi.lock); else pass_n++;
        for (int v = 2; v <= 4; v++) begin
            wait_valid(20, n, ok);
            total_n++; if (!ok || n != 9) $display("FAIL interval45 got %0d want 9", n); else pass_n++;
            total_n++; if (bi.period_x2 !== 6'd9 || bi.match !== 1'b1) $display("FAIL meas45 got p=%0d m=%b want 9 1", bi.period_x2, bi.match); else pass_n++;
            total_n++; if (bi.lock !== (v == 4) || bz.lock !== (v == 4)) $display("FAIL lock45 valid %0d got l=%b l0=%b want %b", v, bi.lock, bz.lock, v == 4); else pass_n++;
        end
        tick;
        total_n++; if (bi.valid !== 1'b0) $display("FAIL valid_pulse got %b want 0", bi.valid); else pass_n++;
    endtask
    task automatic test_stretch(input int from, input int expv, input bit exp_m);
        int n; bit ok, found;
        found = 1'b0;
        pend_from = from; pend = 1;
        for (int i = 0; i < 4 && !found; i++) begin
            wait_valid(20, n, ok);
            if (ok && bi.period_x2 != 6'd9) found = 1'b1;
        end
        total_n++; if (!found) $display("FAIL stretch_seen got none want period %0d", expv); else pass_n++;
        total_n++; if (bi.period_x2 !== 6'(expv) || bi.match !== exp_m || bi.lock !== exp_m) $display("FAIL stretch_meas got p=%0d m=%b l=%b want %0d %b %b", bi.period_x2, bi.match, bi.lock, expv, exp_m, exp_m); else pass_n++;
        total_n++; if (bz.match !== 1'b0 || bz.lock !== 1'b0) $display("FAIL stretch_tol0 got m=%b l=%b want 0 0", bz.match, bz.lock); else pass_n++;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(20, n, ok);
            total_n++; if (!ok || bi.period_x2 !== 6'd9) $display("FAIL restretch_meas got p=%0d want 9", bi.period_x2); else pass_n++;
            if (i == 3) begin
                total_n++; if (bz.lock !== 1'b0 || bi.lock !== exp_m) $display("FAIL relock_early got l=%b l0=%b want %b 0", bi.lock, bz.lock, exp_m); else pass_n++;
            end
        end
        total_n++; if (bi.lock !== 1'b1 || bz.lock !== 1'b1) $display("FAIL relock got l=%b l0=%b want 1 1", bi.lock, bz.lock); else pass_n++;
    endtask
    task automatic test_div5;
        int n; bit ok;
        mode = 5;
        for (int i = 0; i < 3; i++) wait_valid(30, n, ok);
        for (int i = 1; i <= 4; i++) begin
            wait_valid(20, n, ok);
            total_n++; if (!ok || n != 10 || bi.period_x2 !== 6'd10) $display("FAIL div5_meas got p=%0d gap=%0d want 10 10", bi.period_x2, n); else pass_n++;
            total_n++; if (bi.match !== 1'b1 || bz.match !== 1'b0) $display("FAIL div5_match got m=%b m0=%b want 1 0", bi.match, bz.match); else pass_n++;
        end
        total_n++; if (bi.lock !== 1'b1 || bz.lock !== 1'b0) $display("FAIL div5_lock got l=%b l0=%b want 1 0", bi.lock, bz.lock); else pass_n++;
    endtask
    task automatic test_meas_dis;
        int n; bit ok, saw;
        mode = 45;
        for (int i = 0; i < 3; i++) wait_valid(30, n, ok);
        total_n++; if (bi.period_x2 !== 6'd9) $display("FAIL dis_pre got p=%0d want 9", bi.period_x2); else pass_n++;
        for (int i = 0; i < 6; i++) tick;
        en = 1'b0;
        tick;
        total_n++; if (bi.lock !== 1'b0 || bz.lock !== 1'b0) $display("FAIL dis_lock got l=%b l0=%b want 0 0", bi.lock, bz.lock); else pass_n++;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bi.valid) saw = 1'b1;
        end
        total_n++; if (saw) $display("FAIL dis_valid got 1 want 0"); else pass_n++;
        total_n++; if (bi.period_x2 !== 6'd9 || bi.match !== 1'b1) $display("FAIL dis_hold got p=%0d m=%b want 9 1", bi.period_x2, bi.match); else pass_n++;
        en = 1'b1;
        wait_valid(60, n, ok);
        total_n++; if (!ok || bi.period_x2 !== 6'd9 || bi.match !== 1'b1) $display("FAIL reen_meas got ok=%b p=%0d m=%b want 1 9 1", ok, bi.period_x2, bi.match); else pass_n++;
    endtask
    task automatic test_timeout;
        int n; bit ok, saw;
        en = 1'b0; tick;
        mode = 0;
        for (int i = 0; i < 3; i++) tick;
        en = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0; ok = 1'b0;
            while (n < 100 && !ok) begin
                tick; n++;
                if (bi.valid) saw = 1'b1;
                if (bi.err) ok = 1'b1;
            end
            total_n++; if (!ok) $display("FAIL sync_err %0d got timeout want err", k); else pass_n++;
        end
        total_n++; if (n != 63) $display("FAIL err_interval got %0d want 63", n); else pass_n++;
        total_n++; if (saw || bi.lock !== 1'b0 || bi.period_x2 !== 6'd9) $display("FAIL sync_idle got v=%b l=%b p=%0d want 0 0 9", saw, bi.lock, bi.period_x2); else pass_n++;
        mode = 45;
        wait_valid(60, n, ok);
        mode = 0;
        total_n++; if (!ok) $display("FAIL stuck_start got timeout want valid"); else pass_n++;
        n = 0; ok = 1'b0; saw = 1'b0;
        while (n < 100 && !ok) begin
            tick; n++;
            if (bi.valid) saw = 1'b1;
            if (bi.err) ok = 1'b1;
        end
        total_n++; if (!ok || n != 62 || saw) $display("FAIL stuck_err got ok=%b n=%0d v=%b want 1 62 0", ok, n, saw); else pass_n++;
        total_n++; if (bi.period_x2 !== 6'd9 || bi.match !== 1'b1 || bi.lock !== 1'b0) $display("FAIL stuck_hold got p=%0d m=%b l=%b want 9 1 0", bi.period_x2, bi.match, bi.lock); else pass_n++;
        tick;
        total_n++; if (bi.err !== 1'b0) $display("FAIL err_pulse got %b want 0", bi.err); else pass_n++;
    endtask
    task automatic test_async_reset;
        int n; bit ok;
        mode = 45;
        for (int i = 0; i < 8 && bi.lock !== 1'b1; i++) wait_valid(80, n, ok);
        total_n++; if (bi.lock !== 1'b1) $display("FAIL prereset_lock got %b want 1", bi.lock); else pass_n++;
        for (int i = 0; i < 3; i++) tick;
        #2 rst_n = 1'b0;
        #1;
        total_n++; if (bi.period_x2 !== 6'd0 || bi.match !== 1'b0 || bi.lock !== 1'b0 || bi.valid !== 1'b0 || bi.err !== 1'b0) $display("FAIL async_reset got p=%0d m=%b l=%b v=%b e=%b want 0 0 0 0 0", bi.period_x2, bi.match, bi.lock, bi.valid, bi.err); else pass_n++;
        tick;
        rst_n = 1'b1;
        wait_valid(80, n, ok);
        total_n++; if (!ok || bi.period_x2 !== 6'd9 || bi.match !== 1'b1) $display("FAIL post_reset got ok=%b p=%0d m=%b want 1 9 1", ok, bi.period_x2, bi.match); else pass_n++;
    endtask
    initial begin
        test_reset;
        test_ratio_45;
        test_stretch(5, 10, 1'b1);
        test_stretch(4, 11, 1'b0);
        test_div5;
        test_meas_dis;
        test_timeout;
        test_async_reset;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/div_half_checker.md
Name: div_half_checker

Overview:
- Measurement-side companion to the half-integer (N.5) clock divider.
- Samples a divided clock in the `clk` domain and measures two of its periods in `clk` cycles. For a N.5 ratio, two periods are the integer 2N+1.
- Compares the result against an expected ratio and reports the measurement, a per-measurement match flag, a lock indication and a timeout error.
- Used in clock-generation subsystems and benches to self-check divider output frequency.

Parameters:
- NUM_X2, 9: expected two-period length in `clk` cycles (2×ratio; 9 means 4.5); must be ≥3.
- TOL, 1: allowed absolute deviation |period_x2 − NUM_X2| for a match.
- CNT_W, 16: counter/result width; timeout value is 2^CNT_W−1.
- SYNC_STAGES, 2: synchronizer depth for clk_div_in; must be ≥2.
- LOCK_CNT, 4: consecutive matches required to assert lock; must be ≥1.

Ports:
- clk  in  1  reference clock, the divider source clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_div_in  in  1  divided clock under test, treated as asynchronous.
- meas_en  in  1  measurement enable, level-sensitive.
- period_x2  out  CNT_W  last measured two-period length in `clk` cycles.
- valid  out  1  one-cycle pulse when period_x2/match are updated.
- match  out  1  last measurement within NUM_X2±TOL.
- lock  out  1  LOCK_CNT consecutive matches seen and no error since.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: period_x2=0, valid=0, match=0, lock=0, err=0.
  - Internal state: synchronizer flops=0, state=IDLE, counters=0.
- Input conditioning:
  - clk_div_in passes through a SYNC_STAGES-flop synchronizer, then a previous-value register.
  - edge = sync_out & ~prev, a single-cycle rising-edge pulse.
- Counter behaviour:
  - cnt increments by 1 every cycle in SYNC and MEAS and saturates at 2^CNT_W−1.
  - Setting cnt=1 on an edge cycle makes the measured value equal the exact cycle distance between edge pulses.
- IDLE:
  - Holds cnt=0, edge_idx=0, lock=0.
  - meas_en=1 → SYNC, with cnt=0.
- SYNC (wait for start edge):
  - On edge: → MEAS, cnt=1, edge_idx=0.
  - On cnt reaching max: err pulses for 1 cycle, lock=0, cnt=0, stay in SYNC.
- MEAS:
  - On edge with edge_idx=0: edge_idx=1 and cnt continues counting.
  - On edge with edge_idx=1 (end of second period):
    - Next cycle: period_x2=cnt, match=(|cnt−NUM_X2|≤TOL), valid=1 for exactly 1 cycle.
    - This cycle: cnt=1 and edge_idx=0. The end edge is the next start edge, so measurements are back-to-back with no gap.
  - On cnt reaching max without an end edge: err pulses 1 cycle, lock=0, match_run=0, → SYNC with cnt=0. period_x2 and match hold.
- Lock:
  - match_run counter (width ≥ clog2(LOCK_CNT+1)) increments on each valid with match=1, saturating at LOCK_CNT.
  - Clears on valid with match=0, on err, or on leaving to IDLE.
  - lock = (match_run==LOCK_CNT), registered, so it asserts in the same cycle as the qualifying valid.
- meas_en deasserted in any state → IDLE next cycle. Any in-flight measurement is discarded; valid does not pulse. lock=0. period_x2 and match hold their last values.
- Latency: a clk_div_in rising edge meeting setup produces an edge pulse SYNC_STAGES+1 cycles later. valid follows the end-edge pulse by 1 cycle.
- Simultaneous events:
  - An edge on the same cycle cnt reaches max counts as an edge; no err.
  - meas_en=0 overrides everything.
- The arithmetic for the deviation uses CNT_W+1-bit signed difference. No overflow for any legal parameter.

Test Plan:
- clk_div_in from a 4.5 divider on the same clk, meas_en=1, defaults → after the first start edge, valid every 9 cycles with period_x2=9, match=1; lock=1 on the 4th valid.
- Divider replaced by a ÷5 source (period 10), NUM_X2=9, TOL=1 → period_x2=10, match=1. With TOL=0 → match=0, lock stays 0.
- Locked at 4.5, then one period stretched to 6 cycles → one valid with period_x2=10 or 11 per stretch placement. If out of tolerance, match=0 and lock drops on that valid. Lock reasserts after 4 further good measurements.
- clk_div_in held at 0, CNT_W=6 → err pulses every 63 cycles in SYNC, valid never asserts. Stuck mid-MEAS → single err, return to SYNC, period_x2 unchanged.
- meas_en dropped 3 cycles before an expected valid → no valid, lock=0 next cycle, period_x2 holds 9. Re-enable → first valid 9 cycles after the next start edge.
- rst_n asserted mid-MEAS with lock=1 → all outputs 0 immediately (asynchronous). After release with meas_en=1, normal measurement resumes from SYNC.
